// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : csa_pkg                                                    |
// | Description : Shared definitions for the carry-save accumulator: FSM     |
// |               state encoding and helpers that size the resolution        |
// |               chunk index and the operand counter.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package csa_pkg;

    // Accumulate operands / resolve carry-save pair / present result.
    localparam logic [1:0] c_st_acc = 2'd0;
    localparam logic [1:0] c_st_res = 2'd1;
    localparam logic [1:0] c_st_out = 2'd2;

    // Number of CHUNK-bit slices needed to cover the accumulator.
    function automatic int calc_nchunk(input int acc_w, input int chunk);
        return (acc_w + chunk - 1) / chunk;
    endfunction

    // Counter must represent 2^GUARD + 1 (the saturated "overflowed" value).
    function automatic int calc_cnt_w(input int guard);
        return guard + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/FAdder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : FAdder                                                     |
// | Description : Single-bit full adder.                                     |
// |   a, b, cin : addend bits                                                |
// |   s         : sum bit                                                    |
// |   cout      : carry-out bit                                              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module FAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csa_row                                                    |
// | Description : Combinational W-bit 3:2 compressor row. Each bit position  |
// |               reduces A, B, C to a sum bit and a carry bit of the same   |
// |               weight; the caller shifts Cout left by one.                |
// |   A, B, C   : W-bit addends                                              |
// |   Sum       : W-bit bitwise sum                                          |
// |   Cout      : W-bit bitwise carry (unshifted)                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csa_row #(
    parameter int W = 8
) (
    output logic [W-1:0] Cout,
    output logic [W-1:0] Sum,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        FAdder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (C[i]),
            .s    (Sum[i]),
            .cout (Cout[i])
        );
    end

endmodule
`default_nettype wire

// File: rtl/csa_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csa_accumulator                                            |
// | Description : Multi-operand accumulator holding its running total as a   |
// |               carry-save pair. The last operand of a group triggers a    |
// |               chunked carry-propagate resolution, after which the result |
// |               is offered on a valid/ready output.                        |
// |   clk, rst_n          : clock, asynchronous active-low reset             |
// |   in_valid/in_ready   : operand handshake                                |
// |   in_data, in_last    : operand and end-of-group marker                  |
// |   out_valid/out_ready : result handshake                                 |
// |   out_sum, out_ovf    : resolved sum mod 2^ACC_W, operand-count overflow |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int GUARD  = 4,
    parameter int CHUNK  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+GUARD-1:0]   out_sum,
    output logic                     out_ovf
);

    localparam int ACC_W  = WIDTH + GUARD;
    localparam int NCHUNK = calc_nchunk(ACC_W, CHUNK);
    localparam int CNT_W  = calc_cnt_w(GUARD);
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'((1 << GUARD) + 1);
    localparam logic [CNT_W-1:0] c_cnt_lim  = CNT_W'(1 << GUARD);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NCHUNK - 1);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_cv;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_cy;

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_row_s;
    logic [ACC_W-1:0] w_row_co;
    logic [PAD_W-1:0] w_s_pad;
    logic [PAD_W-1:0] w_cv_pad;
    logic [PAD_W-1:0] w_s_res_pad;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_unused_co_msb;

    // Operand extension to the accumulator width.
    if (SIGNED) begin : g_ext_signed
        assign w_ext = {{GUARD{in_data[WIDTH-1]}}, in_data};
    end else begin : g_ext_unsigned
        assign w_ext = {{GUARD{1'b0}}, in_data};
    end

    csa_row #(
        .W (ACC_W)
    ) u_row (
        .Cout (w_row_co),
        .Sum  (w_row_s),
        .A    (r_s),
        .B    (r_cv),
        .C    (w_ext)
    );

    // The top carry would land at weight 2^ACC_W, which wraps away.
    assign w_unused_co_msb = w_row_co[ACC_W-1];

    // Zero-pad so the final, possibly partial, chunk can be sliced uniformly.
    assign w_s_pad  = PAD_W'(r_s);
    assign w_cv_pad = PAD_W'(r_cv);

    // Slice select for the chunk currently being resolved.
    always_comb begin
        w_chunk_a = '0;
        w_chunk_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_chunk_a = w_s_pad[k*CHUNK +: CHUNK];
                w_chunk_b = w_cv_pad[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_chunk_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, r_cy};

    // Write the resolved chunk back into S; other slices are untouched, so
    // higher chunks still see their original carry-save bits.
    always_comb begin
        w_s_res_pad = w_s_pad;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_s_res_pad[k*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_acc;
            r_s     <= '0;
            r_cv    <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_cy    <= 1'b0;
        end else begin
            case (r_state)
                c_st_acc: begin
                    if (in_valid) begin
                        r_s  <= w_row_s;
                        r_cv <= {w_row_co[ACC_W-2:0], 1'b0};
                        if (r_cnt != c_cnt_sat) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            r_state <= c_st_res;
                            r_idx   <= '0;
                            r_cy    <= 1'b0;
                        end
                    end
                end
                c_st_res: begin
                    r_s  <= w_s_res_pad[ACC_W-1:0];
                    r_cy <= w_chunk_sum[CHUNK];
                    if (r_idx == c_idx_last) begin
                        r_state <= c_st_out;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_state <= c_st_acc;
                        r_s     <= '0;
                        r_cv    <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_cy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_acc;
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (r_state == c_st_acc);
    assign out_valid = (r_state == c_st_out);
    assign out_sum   = out_valid ? r_s : '0;
    assign out_ovf   = out_valid & (r_cnt > c_cnt_lim);

endmodule
`default_nettype wire
